bram_word_reader: RTL and testbench
===================================

BRAM_WORD_READER -- requirements
Module: bram_word_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning the byte-address width of the BRAM read port.
REQ-002 The block SHALL have parameter NBYTES, default 4, meaning the number of bytes per response word (1..4).
REQ-003 The block SHALL have port clock, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 1, request present.
REQ-006 The block SHALL have port req_ready, output, 1, request accepted this cycle if req_valid is also high.
REQ-007 The block SHALL have port req_addr, input, ADDR_W, byte address of the word's lowest byte (alignment not required).
REQ-008 The block SHALL have port resp_valid, output, 1, resp_data is valid.
REQ-009 The block SHALL have port resp_ready, input, 1, consumer accepts the response.
REQ-010 The block SHALL have port resp_data, output, 8*NBYTES, the assembled little-endian word.
REQ-011 The block SHALL have port bram_en, output, 1, BRAM read-port enable.
REQ-012 The block SHALL have port bram_addr, output, ADDR_W, BRAM read-port address.
REQ-013 The block SHALL have port bram_dout, input, 8, BRAM registered read data, valid one cycle after the enabled read address.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, DRAIN and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE with reset low.
REQ-016 A request SHALL be accepted on the edge where req_valid&req_ready; the block captures req_addr as base and enters ISSUE with byte counter 0.
REQ-017 In ISSUE, bram_en SHALL be 1 and bram_addr SHALL be (base+counter) mod 2^ADDR_W; the counter increments each cycle, and after issue NBYTES-1 the FSM enters DRAIN.
REQ-018 bram_en SHALL be 0 in IDLE, DRAIN and RESP; bram_addr SHALL hold its last value when bram_en is 0.
REQ-019 The byte issued in cycle k SHALL be sampled from bram_dout at the end of cycle k+1 into resp_data bits [8k+7:8k]; sampling is tracked by a registered pending flag and index, not by state alone.
REQ-020 DRAIN SHALL last exactly one cycle (the final byte is latched there), then the FSM enters RESP.
REQ-021 Latency: with NBYTES=4, resp_valid SHALL first be high in the 6th cycle after the acceptance edge.
REQ-022 In RESP, resp_valid SHALL be 1, and resp_data and all state SHALL hold while resp_ready=0.
REQ-023 On resp_valid&resp_ready the FSM SHALL return to IDLE; the next request can be accepted no earlier than the following cycle (one word per NBYTES+3 cycles minimum).
REQ-024 req_addr and req_valid changes after acceptance SHALL have no effect until IDLE.
REQ-025 Address wrap-around SHALL be modulo 2^ADDR_W with no error indication.
REQ-026 resp_data SHALL be cleared to 0 on acceptance of each request, so that unfilled bytes are never stale.

Reset
REQ-027 Asserting reset at any time SHALL immediately (asynchronously) force IDLE, counter 0, pending 0, bram_en=0, bram_addr=0, resp_valid=0, resp_data=0 and req_ready=0.
REQ-028 After reset deasserts, req_ready SHALL be 1 from the first cycle, and any in-flight read SHALL be discarded with no response produced.

Verification
REQ-029 Aligned read: mem[0x010..0x013]=13,05,00,00 and request 0x010 -> bram_addr 010,011,012,013 on 4 consecutive bram_en cycles; resp_data=0x00000513 on the 6th cycle after acceptance.
REQ-030 Wrap: mem[0xFFE]=AA, [0xFFF]=BB, [0x000]=CC, [0x001]=DD and request 0xFFE -> bram_addr FFE,FFF,000,001; resp_data=0xDDCCBBAA.
REQ-031 Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_data stable, req_ready=0, bram_en=0 throughout; handshake on cycle 11 returns to IDLE.
REQ-032 Back-to-back: req_valid held high with addresses 0x100 then 0x101 and resp_ready=1 -> acceptances are 7 cycles apart; second resp_data = bytes 0x101..0x104 little-endian.
REQ-033 Reset mid-op: reset pulsed during the 3rd ISSUE cycle -> bram_en and resp_valid drop without waiting for a clock edge and no response appears; a subsequent request to 0x010 returns 0x00000513.
REQ-034 NBYTES=2 build: request 0x010 -> two issues; resp_data=0x0513 on the 4th cycle after acceptance.

Source files
------------

// File: rtl/bram_word_reader.sv
// Assembles an NBYTES little-endian word from a byte-wide BRAM read port with
// one-cycle registered read latency, behind valid/ready request and response channels.
module bram_word_reader #(
  parameter int ADDR_W = 12,
  parameter int NBYTES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [8*NBYTES-1:0]   resp_data,
  output logic                  bram_en,
  output logic [ADDR_W-1:0]     bram_addr,
  input  logic [7:0]            bram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                accept_s;
  logic [1:0]          cnt_r;
  logic [1:0]          cnt_s;
  logic                pend_r;
  logic                pend_s;
  logic [1:0]          pidx_r;
  logic [1:0]          pidx_s;
  logic                bram_en_r;
  logic                bram_en_s;
  logic [ADDR_W-1:0]   bram_addr_r;
  logic [ADDR_W-1:0]   bram_addr_s;
  logic                resp_valid_r;
  logic                resp_valid_s;
  logic [8*NBYTES-1:0] resp_data_r;

  // Ready is gated by reset so it is low during reset and high in the first cycle after it.
  assign req_ready  = (state_r == IDLE) && !reset;
  assign accept_s   = (state_r == IDLE) && req_valid;
  assign bram_en    = bram_en_r;
  assign bram_addr  = bram_addr_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = ISSUE;
        else          next_state_s = IDLE;
      end
      ISSUE: begin
        if (cnt_r == 2'(NBYTES - 1)) next_state_s = DRAIN;
        else                         next_state_s = ISSUE;
      end
      DRAIN:   next_state_s = RESP;
      RESP: begin
        if (resp_ready) next_state_s = IDLE;
        else            next_state_s = RESP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, byte counter and sampling tracker.
  always_comb begin
    cnt_s       = cnt_r;
    bram_addr_s = bram_addr_r;
    pend_s      = 1'b0;
    pidx_s      = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = 2'd0;
        if (accept_s) bram_addr_s = req_addr;
        else          bram_addr_s = bram_addr_r;
      end
      ISSUE: begin
        // The byte issued now arrives next cycle; remember which lane it fills.
        pend_s = 1'b1;
        if (next_state_s == ISSUE) begin
          cnt_s       = cnt_r + 2'd1;
          bram_addr_s = bram_addr_r + ADDR_W'(1'b1);
        end else begin
          cnt_s       = 2'd0;
          bram_addr_s = bram_addr_r;
        end
      end
      default: begin
        cnt_s = 2'd0;
      end
    endcase
    bram_en_s    = (next_state_s == ISSUE);
    resp_valid_s = (next_state_s == RESP);
  end

  // Output, counter and data-assembly registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r        <= 2'd0;
      pend_r       <= 1'b0;
      pidx_r       <= 2'd0;
      bram_en_r    <= 1'b0;
      bram_addr_r  <= {ADDR_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_data_r  <= {(8*NBYTES){1'b0}};
    end else begin
      cnt_r        <= cnt_s;
      pend_r       <= pend_s;
      pidx_r       <= pidx_s;
      bram_en_r    <= bram_en_s;
      bram_addr_r  <= bram_addr_s;
      resp_valid_r <= resp_valid_s;
      if (accept_s) begin
        resp_data_r <= {(8*NBYTES){1'b0}};
      end else if (pend_r) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (int'(pidx_r) == i) resp_data_r[8*i +: 8] <= bram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_word_reader.sv
// Randomized and directed bench for bram_word_reader: a transaction-level timing
// model checks every cycle; literal expectations pin the model on known memory contents.
module tb_bram_word_reader;

  localparam int NB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = 12'h000;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        bram_en;
  logic [11:0] bram_addr;
  logic [7:0]  bram_dout;

  logic        d2_req_valid = 1'b0;
  logic        d2_req_ready;
  logic [11:0] d2_req_addr = 12'h000;
  logic        d2_resp_valid;
  logic        d2_resp_ready = 1'b1;
  logic [15:0] d2_resp_data;
  logic        d2_bram_en;
  logic [11:0] d2_bram_addr;
  logic [7:0]  d2_bram_dout;

  logic [7:0]  mem [0:4095];
  int          n_chk = 0;
  int          n_fail = 0;

  bram_word_reader #(.ADDR_W(12), .NBYTES(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout)
  );

  bram_word_reader #(.ADDR_W(12), .NBYTES(2)) dut2 (
    .clock(clock), .reset(reset), .req_valid(d2_req_valid), .req_ready(d2_req_ready),
    .req_addr(d2_req_addr), .resp_valid(d2_resp_valid), .resp_ready(d2_resp_ready),
    .resp_data(d2_resp_data), .bram_en(d2_bram_en), .bram_addr(d2_bram_addr),
    .bram_dout(d2_bram_dout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bram_en) bram_dout <= mem[bram_addr];
    if (d2_bram_en) d2_bram_dout <= mem[d2_bram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Transaction-level model: cycles elapsed since acceptance determine every output.
  bit          act = 1'b0;
  int          t = 0;
  logic [11:0] base = 12'h000;
  logic [11:0] hold_addr = 12'h000;
  logic [31:0] word = 32'h0;

  always @(negedge clock) begin
    logic        e_en;
    logic        e_rv;
    logic [11:0] e_addr;
    if (reset) begin
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_bram_en", {31'b0, bram_en}, 32'd0);
      chk("rst_bram_addr", {20'b0, bram_addr}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      act = 1'b0;
      hold_addr = 12'h000;
    end else begin
      e_en   = act && (t <= NB);
      e_rv   = act && (t >= NB + 2);
      e_addr = e_en ? base + 12'(t - 1) : hold_addr;
      chk("req_ready", {31'b0, req_ready}, {31'b0, !act});
      chk("bram_en", {31'b0, bram_en}, {31'b0, e_en});
      chk("bram_addr", {20'b0, bram_addr}, {20'b0, e_addr});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_rv});
      if (e_rv) chk("resp_data", resp_data, word);
      if (e_en) hold_addr = e_addr;
      if (!act) begin
        if (req_valid) begin
          act  = 1'b1;
          t    = 1;
          base = req_addr;
          word = 32'h0;
          for (int k = 0; k < NB; k++) word[8*k +: 8] = mem[base + 12'(k)];
        end
      end else if (e_rv && resp_ready) begin
        act = 1'b0;
      end else begin
        t++;
      end
    end
  end

  // One request with optional backpressure; checks latency and a literal word.
  task automatic do_req(input logic [11:0] addr, input int bp, input logic [31:0] lit);
    int c;
    int n;
    bit acc;
    resp_ready = (bp == 0);
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clock); #1;
      acc = req_ready;
      n++;
      if (!acc) begin @(posedge clock); #1; end
    end
    chk("accept_timeout", {31'b0, acc}, 32'd1);
    @(posedge clock); #1;
    req_valid = 1'($urandom_range(0, 1));
    req_addr  = 12'($urandom);
    c = 1;
    while (c < 30) begin
      @(negedge clock); #1;
      if (resp_valid) break;
      c++;
      @(posedge clock); #1;
      req_valid = 1'b0;
      req_addr  = 12'($urandom);
    end
    req_valid = 1'b0;
    chk("latency", c, NB + 2);
    chk("word_lit", resp_data, lit);
    if (bp > 0) begin
      repeat (bp - 1) begin
        @(posedge clock); #1;
        @(negedge clock); #1;
        chk("bp_data", resp_data, lit);
        chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        chk("bp_bram_en", {31'b0, bram_en}, 32'd0);
      end
      @(posedge clock); #1;
      resp_ready = 1'b1;
      @(negedge clock); #1;
      chk("bp_last_valid", {31'b0, resp_valid}, 32'd1);
    end
    @(posedge clock); #1;
    resp_ready = 1'b0;
    @(negedge clock); #1;
    chk("back_idle_valid", {31'b0, resp_valid}, 32'd0);
    chk("back_idle_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int c;
    int cyc;
    int acc_cnt;
    int acc_cyc [2];
    logic [31:0] first_word;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    mem[12'h010] = 8'h13; mem[12'h011] = 8'h05; mem[12'h012] = 8'h00; mem[12'h013] = 8'h00;
    mem[12'hFFE] = 8'hAA; mem[12'hFFF] = 8'hBB; mem[12'h000] = 8'hCC; mem[12'h001] = 8'hDD;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33;
    mem[12'h103] = 8'h44; mem[12'h104] = 8'h55;

    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock); #1;
    chk("first_cycle_ready", {31'b0, req_ready}, 32'd1);

    // Two-byte build.
    @(posedge clock); #1;
    d2_req_valid = 1'b1;
    d2_req_addr  = 12'h010;
    @(negedge clock); #1;
    chk("d2_ready", {31'b0, d2_req_ready}, 32'd1);
    @(posedge clock); #1;
    d2_req_valid = 1'b0;
    c = 1;
    while (c < 20) begin
      @(negedge clock); #1;
      if (d2_resp_valid) break;
      c++;
      @(posedge clock); #1;
    end
    chk("d2_latency", c, 4);
    chk("d2_word", {16'b0, d2_resp_data}, 32'h0000_0513);

    do_req(12'h010, 0, 32'h0000_0513);
    do_req(12'hFFE, 0, 32'hDDCC_BBAA);
    do_req(12'h010, 10, 32'h0000_0513);

    // Back-to-back with req_valid held high.
    resp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_addr  = 12'h100;
    acc_cnt = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    first_word = 32'h0;
    cyc = 0;
    while (cyc < 40 && acc_cnt < 2) begin
      @(negedge clock); #1;
      if (resp_valid) first_word = resp_data;
      if (req_ready) begin
        acc_cyc[acc_cnt] = cyc;
        acc_cnt++;
      end
      @(posedge clock); #1;
      cyc++;
      if (acc_cnt == 1) req_addr = 12'h101;
    end
    req_valid = 1'b0;
    chk("b2b_count", acc_cnt, 2);
    chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 7);
    chk("b2b_first", first_word, 32'h4433_2211);
    c = 1;
    while (c < 20) begin
      @(negedge clock); #1;
      if (resp_valid) break;
      c++;
      @(posedge clock); #1;
    end
    chk("b2b_second", resp_data, 32'h5544_3322);
    @(posedge clock); #1;
    resp_ready = 1'b0;

    // Reset during the third issue cycle.
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_addr  = 12'h010;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("pre_rst_en", {31'b0, bram_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_en", {31'b0, bram_en}, 32'd0);
    chk("async_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clock); #3 reset = 1'b0;
    resp_ready = 1'b1;
    repeat (10) begin
      @(negedge clock); #1;
      chk("no_stale_resp", {31'b0, resp_valid}, 32'd0);
    end
    do_req(12'h010, 0, 32'h0000_0513);

    // Random traffic, wrap-biased addresses and occasional async reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      req_valid  = ($urandom_range(0, 2) != 0);
      req_addr   = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3)) : 12'($urandom);
      resp_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(posedge clock); #3 reset = 1'b0;
      end
    end
    @(posedge clock); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (12) @(posedge clock);
    @(negedge clock); #1;
    chk("final_idle", {31'b0, req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
